// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch stage of the 5-stage RISC-V pipeline.
package fetch_ctrl_pkg;

    // Fetch sequencing states: normal fetch plus the three-step miss/refill sequence.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        REFILL    = 2'd2,
        RESUME    = 2'd3
    } fetch_state_e;

    // add x0,x0,x0 - the bubble placed into IF/ID when insert_nop is high.
    localparam logic [31:0] NOP_INSN = 32'h00000033;

    localparam int DEF_MEM_LAT     = 1;
    localparam int DEF_FLUSH_DEPTH = 2;
    localparam int DEF_CNT_W       = 16;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_bits(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle: hazard/cache status in, pipeline enables and refill strobe out.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             hit;
    logic             pc_src;
    logic             hazard_stall;
    logic             pc_en;
    logic             if_en;
    logic             insert_nop;
    logic             cache_we;
    logic             busy;
    logic [CNT_W-1:0] miss_count;

    // Pipeline side: supplies cache/branch/hazard status, consumes the enables.
    modport master (
        output hit, pc_src, hazard_stall,
        input  pc_en, if_en, insert_nop, cache_we, busy, miss_count
    );

    // Controller side.
    modport slave (
        input  hit, pc_src, hazard_stall,
        output pc_en, if_en, insert_nop, cache_we, busy, miss_count
    );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc until all-ones, clear has priority.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: PC/IF-ID enables, branch-flush NOPs and cache-miss refill.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int MEM_LAT     = DEF_MEM_LAT,
    parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    fetch_ctrl_if.slave  fif
);

    localparam int WAIT_W  = cnt_bits(MEM_LAT);
    localparam int FLUSH_W = cnt_bits(FLUSH_DEPTH - 1);

    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(MEM_LAT);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_DEPTH - 1);

    fetch_state_e       state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [FLUSH_W-1:0] flush_cnt, flush_nxt;
    logic               pc_en_c, if_en_c, cache_we_c, miss_inc;
    logic [CNT_W-1:0]   miss_q;

    // State, BRAM wait counter and flush counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    // Next-state and Mealy enables; priority is redirect, then miss, then load-use stall.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        flush_nxt  = flush_cnt;
        pc_en_c    = 1'b0;
        if_en_c    = 1'b0;
        cache_we_c = 1'b0;
        miss_inc   = 1'b0;

        if (fif.pc_src) begin
            // Redirect wins everywhere: abandon any refill and start a fresh flush window.
            state_nxt = RUN;
            wait_nxt  = '0;
            flush_nxt = FLUSH_LOAD;
            pc_en_c   = 1'b1;
            if_en_c   = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (!fif.hit) begin
                        wait_nxt  = WAIT_LOAD;
                        state_nxt = MISS_WAIT;
                        miss_inc  = 1'b1;
                    end else if (flush_cnt != '0) begin
                        // Capture a NOP slot; a NOP has no dependency so the stall is ignored.
                        pc_en_c   = 1'b1;
                        if_en_c   = 1'b1;
                        flush_nxt = flush_cnt - FLUSH_W'(1);
                    end else if (!fif.hazard_stall) begin
                        pc_en_c = 1'b1;
                        if_en_c = 1'b1;
                    end
                end
                MISS_WAIT: begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state_nxt = REFILL;
                    end
                end
                REFILL: begin
                    cache_we_c = 1'b1;
                    state_nxt  = RESUME;
                end
                RESUME: begin
                    // Gives the cache read port a cycle to present the refilled line.
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_miss_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (miss_inc),
        .count (miss_q)
    );

    // Outputs are forced low while reset is asserted so nothing leaks during the reset cycle.
    assign fif.pc_en      = !reset && pc_en_c;
    assign fif.if_en      = !reset && if_en_c;
    assign fif.cache_we   = !reset && cache_we_c;
    assign fif.insert_nop = !reset && (fif.pc_src || (flush_cnt != '0));
    assign fif.busy       = !reset && (state != RUN);
    assign fif.miss_count = reset ? '0 : miss_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: two instances with different latency/flush/width settings
// share one stimulus stream and are compared every cycle against a cycle-budget reference model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int N_DUT = 2;
    localparam int LAT_A = 1, FD_A = 2, CW_A = 16;
    localparam int LAT_B = 3, FD_B = 3, CW_B = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic hit = 1'b1;
    logic pc_src = 1'b0;
    logic hazard_stall = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    fetch_ctrl_if #(.CNT_W(CW_A)) fif_a ();
    fetch_ctrl_if #(.CNT_W(CW_B)) fif_b ();

    assign fif_a.hit          = hit;
    assign fif_a.pc_src       = pc_src;
    assign fif_a.hazard_stall = hazard_stall;
    assign fif_b.hit          = hit;
    assign fif_b.pc_src       = pc_src;
    assign fif_b.hazard_stall = hazard_stall;

    fetch_ctrl #(.MEM_LAT(LAT_A), .FLUSH_DEPTH(FD_A), .CNT_W(CW_A)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .fif   (fif_a.slave)
    );

    fetch_ctrl #(.MEM_LAT(LAT_B), .FLUSH_DEPTH(FD_B), .CNT_W(CW_B)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .fif   (fif_b.slave)
    );

    // Reference model: a miss costs a stall budget of MEM_LAT+2 cycles after the miss cycle,
    // the refill strobe falls on the second-to-last stalled cycle; the flush is a NOP budget.
    int m_lat  [N_DUT] = '{LAT_A, LAT_B};
    int m_fd   [N_DUT] = '{FD_A, FD_B};
    int m_max  [N_DUT] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    int m_stall[N_DUT];
    int m_nops [N_DUT];
    int m_miss [N_DUT];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_and_check(input int k);
        logic e_pc, e_if, e_nop, e_we, e_busy;
        int   e_cnt;
        logic [31:0] o_pc, o_if, o_nop, o_we, o_busy, o_cnt;
        string nm;

        e_pc = 0; e_if = 0; e_nop = 0; e_we = 0; e_busy = 0; e_cnt = 0;
        if (!reset) begin
            e_busy = (m_stall[k] != 0);
            e_nop  = pc_src || (m_nops[k] != 0);
            e_cnt  = m_miss[k];
            if (pc_src) begin
                e_pc = 1; e_if = 1;
            end else if (m_stall[k] == 0) begin
                if (hit && ((m_nops[k] != 0) || !hazard_stall)) begin
                    e_pc = 1; e_if = 1;
                end
            end else begin
                e_we = (m_stall[k] == 2);
            end
        end

        if (k == 0) begin
            nm = "a";
            o_pc = 32'(fif_a.pc_en); o_if = 32'(fif_a.if_en); o_nop = 32'(fif_a.insert_nop);
            o_we = 32'(fif_a.cache_we); o_busy = 32'(fif_a.busy); o_cnt = 32'(fif_a.miss_count);
        end else begin
            nm = "b";
            o_pc = 32'(fif_b.pc_en); o_if = 32'(fif_b.if_en); o_nop = 32'(fif_b.insert_nop);
            o_we = 32'(fif_b.cache_we); o_busy = 32'(fif_b.busy); o_cnt = 32'(fif_b.miss_count);
        end

        check({nm, ".pc_en"},      o_pc,   32'(e_pc));
        check({nm, ".if_en"},      o_if,   32'(e_if));
        check({nm, ".insert_nop"}, o_nop,  32'(e_nop));
        check({nm, ".cache_we"},   o_we,   32'(e_we));
        check({nm, ".busy"},       o_busy, 32'(e_busy));
        check({nm, ".miss_count"}, o_cnt,  32'(e_cnt));

        // Advance the model to the next cycle.
        if (reset) begin
            m_stall[k] = 0; m_nops[k] = 0; m_miss[k] = 0;
        end else if (pc_src) begin
            m_stall[k] = 0; m_nops[k] = m_fd[k] - 1;
        end else if (m_stall[k] != 0) begin
            m_stall[k]--;
        end else if (!hit) begin
            m_stall[k] = m_lat[k] + 2;
            if (m_miss[k] < m_max[k]) m_miss[k]++;
        end else if (m_nops[k] != 0) begin
            m_nops[k]--;
        end
    endtask

    // One clock cycle: drive on the falling edge, sample mid-low-phase, then advance the model.
    task automatic step(input logic r, input logic h, input logic p, input logic hz);
        @(negedge clock);
        reset = r; hit = h; pc_src = p; hazard_stall = hz;
        #2;
        for (int k = 0; k < N_DUT; k++) model_and_check(k);
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < N_DUT; k++) begin
            m_stall[k] = 0; m_nops[k] = 0; m_miss[k] = 0;
        end

        // Reset held three cycles, then plain hit fetches.
        repeat (3) step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);

        // Single miss followed by hits.
        step(0, 0, 0, 0);
        repeat (8) step(0, 1, 0, 0);

        // Redirect with hits: NOP window.
        step(0, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0);

        // Miss, then redirect while waiting on memory.
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        repeat (5) step(0, 1, 0, 0);

        // Two-cycle load-use stall, then a stall overlapping a flush window.
        repeat (2) step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        repeat (3) step(0, 1, 0, 1);
        step(0, 1, 0, 0);

        // Back-to-back redirects reload the flush window.
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        repeat (4) step(0, 1, 0, 0);

        // Continuous misses drive the narrow counter into saturation.
        repeat (130) step(0, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0);
        check("b.saturated", 32'(fif_b.miss_count), 32'h0000_000F);

        // Miss, then reset asserted while instance a is in REFILL.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("a.count_after_reset", 32'(fif_a.miss_count), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < 82),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 20));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
